// File: rtl/tap_buffer_sequencer.sv
// Circular delay-line sequencer for the FIR sample RAM. Each accepted sample is written
// once, then the newest NTAPS samples are streamed out newest-first under t_valid/t_ready.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
// A valid source holds its data stable until that edge. Ready may be driven by the sink
// independently of valid.
module tap_buffer_sequencer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int NTAPS  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              t_valid,
    input  logic              t_ready,
    output logic [DATA_W-1:0] t_data,
    output logic [ADDR_W-1:0] t_idx,
    output logic              t_last
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam logic [ADDR_W:0] LAST_K  = (ADDR_W+1)'(NTAPS - 1);
    localparam logic [ADDR_W:0] NTAPS_K = (ADDR_W+1)'(NTAPS);

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     fill;
    logic [ADDR_W:0]     k;

    // Two-stage read tag pipeline: iss_* rides with ram_raddr, ret_* with ram_rdata.
    logic                iss_v, iss_zero, iss_last;
    logic [ADDR_W-1:0]   iss_idx;
    logic                ret_v, ret_zero, ret_last;
    logic [ADDR_W-1:0]   ret_idx;

    // Output FIFO sized so that every read already in the pipeline always has a slot.
    logic [DATA_W-1:0]   f_data [4];
    logic [ADDR_W-1:0]   f_idx  [4];
    logic                f_last [4];
    logic [1:0]          f_wp, f_rp;
    logic [2:0]          f_cnt;

    logic                pop;
    logic [2:0]          commit;
    logic                can_issue;

    assign pop       = t_valid && t_ready;
    assign commit    = f_cnt + {2'b0, iss_v} + {2'b0, ret_v} - {2'b0, pop};
    assign can_issue = (commit < 3'd3);

    assign t_valid = (f_cnt != 3'd0);
    assign t_data  = f_data[f_rp];
    assign t_idx   = f_idx[f_rp];
    assign t_last  = f_last[f_rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_ready   <= 1'b0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_raddr <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            k         <= '0;
            iss_v     <= 1'b0;
            iss_zero  <= 1'b0;
            iss_last  <= 1'b0;
            iss_idx   <= '0;
            ret_v     <= 1'b0;
            ret_zero  <= 1'b0;
            ret_last  <= 1'b0;
            ret_idx   <= '0;
        end else begin
            ram_we   <= 1'b0;
            iss_v    <= 1'b0;
            ret_v    <= iss_v;
            ret_zero <= iss_zero;
            ret_last <= iss_last;
            ret_idx  <= iss_idx;
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        ram_we    <= 1'b1;
                        ram_waddr <= wr_ptr;
                        ram_wdata <= s_data;
                        s_ready   <= 1'b0;
                        state     <= WRITE;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    // Tap 0 read goes out on the cycle after the write, never colliding with it.
                    wr_ptr    <= wr_ptr + 1'b1;
                    fill      <= (fill == NTAPS_K) ? fill : fill + 1'b1;
                    ram_raddr <= ram_waddr;
                    iss_v     <= 1'b1;
                    iss_idx   <= '0;
                    iss_zero  <= 1'b0;
                    iss_last  <= (LAST_K == '0);
                    k         <= (ADDR_W+1)'(1);
                    state     <= (LAST_K == '0) ? DRAIN : READ;
                end
                READ: begin
                    if (can_issue) begin
                        ram_raddr <= ram_waddr - k[ADDR_W-1:0];
                        iss_v     <= 1'b1;
                        iss_idx   <= k[ADDR_W-1:0];
                        iss_zero  <= (k >= fill);
                        iss_last  <= (k == LAST_K);
                        k         <= k + 1'b1;
                        if (k == LAST_K) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && t_last) begin
                        s_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_wp  <= '0;
            f_rp  <= '0;
            f_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                f_data[i] <= '0;
                f_idx[i]  <= '0;
                f_last[i] <= 1'b0;
            end
        end else begin
            if (ret_v) begin
                f_data[f_wp] <= ret_zero ? '0 : ram_rdata;
                f_idx[f_wp]  <= ret_idx;
                f_last[f_wp] <= ret_last;
                f_wp         <= f_wp + 1'b1;
            end
            if (pop) f_rp <= f_rp + 1'b1;
            f_cnt <= f_cnt + {2'b0, ret_v} - {2'b0, pop};
        end
    end

endmodule

// File: tb/tb_tap_buffer_sequencer.sv
// Bench for tap_buffer_sequencer: unit 0 runs with NTAPS=4, unit 1 with NTAPS=256,
// each backed by a behavioural synchronous RAM and checked against a sample-history model.
module tb_tap_buffer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid   [2];
    logic        s_ready   [2];
    logic [63:0] s_data    [2];
    logic [63:0] ram_wdata [2];
    logic [7:0]  ram_waddr [2];
    logic        ram_we    [2];
    logic [7:0]  ram_raddr [2];
    logic [63:0] ram_rdata [2];
    logic        t_valid   [2];
    logic        t_ready   [2];
    logic [63:0] t_data    [2];
    logic [7:0]  t_idx     [2];
    logic        t_last    [2];

    logic [63:0] mem [2][256];
    logic [63:0] hist0[$];
    logic [63:0] hist1[$];
    int total = 0;
    int bad = 0;

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ram_we[u]) mem[u][ram_waddr[u]] <= ram_wdata[u];
            ram_rdata[u] <= mem[u][ram_raddr[u]];
        end
    end

    tap_buffer_sequencer #(.DATA_W(64), .ADDR_W(8), .NTAPS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
        .ram_wdata(ram_wdata[0]), .ram_waddr(ram_waddr[0]), .ram_we(ram_we[0]),
        .ram_raddr(ram_raddr[0]), .ram_rdata(ram_rdata[0]),
        .t_valid(t_valid[0]), .t_ready(t_ready[0]), .t_data(t_data[0]),
        .t_idx(t_idx[0]), .t_last(t_last[0])
    );

    tap_buffer_sequencer #(.DATA_W(64), .ADDR_W(8), .NTAPS(256)) dut256 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .ram_wdata(ram_wdata[1]), .ram_waddr(ram_waddr[1]), .ram_we(ram_we[1]),
        .ram_raddr(ram_raddr[1]), .ram_rdata(ram_rdata[1]),
        .t_valid(t_valid[1]), .t_ready(t_ready[1]), .t_data(t_data[1]),
        .t_idx(t_idx[1]), .t_last(t_last[1])
    );

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [278:0] out_vec(input int u);
        return {s_ready[u], ram_we[u], ram_waddr[u], ram_wdata[u], ram_raddr[u],
                t_valid[u], t_data[u], t_idx[u], t_last[u]};
    endfunction

    // Driver + scoreboard for one sample and its tap stream. Entered and left at posedge+1.
    task automatic run_stream(input int u, input logic [63:0] d, input bit rnd_ready,
                              input bit hold_valid, output int wait_n);
        logic [63:0] exp_q[$];
        logic [63:0] exp_d, pd;
        logic [7:0]  pi;
        logic        pl;
        int nt, len, cyc, got, first_v, last_pop;
        bit ready_seen, prev_stall;
        nt = (u == 0) ? 4 : 256;
        s_valid[u] = 1'b1;
        s_data[u]  = d;
        wait_n = 0;
        while (s_ready[u] !== 1'b1 && wait_n < 1000) begin
            @(posedge clk); #1;
            wait_n++;
        end
        if (wait_n >= 1000) begin
            total++; bad++;
            $display("FAIL accept u=%0d: s_ready=%b after %0d cycles, required 1", u, s_ready[u], wait_n);
            s_valid[u] = 1'b0;
            return;
        end
        // Model: the newest NTAPS samples, newest first, zero beyond the history.
        if (u == 0) hist0.push_back(d); else hist1.push_back(d);
        len = (u == 0) ? hist0.size() : hist1.size();
        for (int kk = 0; kk < nt; kk++) begin
            if (kk < len) exp_q.push_back((u == 0) ? hist0[len-1-kk] : hist1[len-1-kk]);
            else exp_q.push_back(64'd0);
        end
        cyc = 0; got = 0; first_v = -1; last_pop = -1;
        ready_seen = 0; prev_stall = 0; pd = '0; pi = '0; pl = 1'b0;
        while (got < nt && cyc < nt + 100) begin
            @(posedge clk); #1;
            cyc++;
            if (!hold_valid) s_valid[u] = 1'b0;
            else if (s_ready[u] === 1'b1) ready_seen = 1;
            t_ready[u] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                total++;
                if (t_valid[u] !== 1'b1 || t_data[u] !== pd || t_idx[u] !== pi || t_last[u] !== pl) begin
                    bad++;
                    $display("FAIL hold u=%0d cyc=%0d: got v=%b d=%h i=%0d l=%b, required v=1 d=%h i=%0d l=%b",
                             u, cyc, t_valid[u], t_data[u], t_idx[u], t_last[u], pd, pi, pl);
                end
            end
            if (t_valid[u] === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                if (t_ready[u]) begin
                    exp_d = exp_q.pop_front();
                    total++;
                    if (t_data[u] !== exp_d || t_idx[u] !== 8'(got) || t_last[u] !== (got == nt - 1)) begin
                        bad++;
                        $display("FAIL tap u=%0d k=%0d: got d=%h i=%0d l=%b, required d=%h i=%0d l=%b",
                                 u, got, t_data[u], t_idx[u], t_last[u], exp_d, got, (got == nt - 1));
                    end
                    got++;
                    if (got == nt) last_pop = cyc;
                end
            end
            prev_stall = (t_valid[u] === 1'b1) && !t_ready[u];
            pd = t_data[u]; pi = t_idx[u]; pl = t_last[u];
        end
        if (got < nt) begin
            total++; bad++;
            $display("FAIL stream_len u=%0d: got %0d taps, required %0d", u, got, nt);
        end
        if (!rnd_ready) begin
            total++;
            if (first_v != 4) begin
                bad++;
                $display("FAIL first_valid u=%0d: cycle %0d, required 4", u, first_v);
            end
            total++;
            if (last_pop != nt + 3) begin
                bad++;
                $display("FAIL last_pop u=%0d: cycle %0d, required %0d", u, last_pop, nt + 3);
            end
        end
        if (hold_valid) begin
            total++;
            if (ready_seen) begin
                bad++;
                $display("FAIL busy_ready u=%0d: s_ready rose mid-stream, required 0", u);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            total++;
            if (out_vec(u) !== '0) begin
                bad++;
                $display("FAIL reset_outputs u=%0d: got %h, required 0", u, out_vec(u));
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int w;
        run_stream(0, 64'hA, 0, 0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 1; i <= 6; i++) run_stream(0, 64'(i), 0, 0, w);
    endtask

    task automatic test_wrap();
        int w;
        for (int i = 1; i <= 300; i++) run_stream(1, 64'(i), 0, 0, w);
    endtask

    task automatic test_backpressure();
        int w;
        for (int i = 0; i < 8; i++) run_stream(0, rnd64(), 1, 0, w);
    endtask

    task automatic test_hold_valid();
        int w;
        run_stream(0, rnd64(), 0, 1, w);
        for (int i = 0; i < 3; i++) begin
            run_stream(0, rnd64(), (i == 1), 1, w);
            total++;
            if (w != 1) begin
                bad++;
                $display("FAIL next_accept: waited %0d cycles after t_last pop, required 1", w);
            end
        end
        s_valid[0] = 1'b0;
    endtask

    task automatic test_mid_reset();
        int w;
        s_valid[0] = 1'b1;
        s_data[0]  = rnd64();
        w = 0;
        while (s_ready[0] !== 1'b1 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        s_valid[0] = 1'b0;
        t_ready[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_vec(0) !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h, required 0", out_vec(0));
        end
        hist0.delete();
        hist1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t_ready[0] = 1'b1;
        run_stream(0, rnd64(), 0, 0, w);
        run_stream(0, rnd64(), 1, 0, w);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            s_valid[u] = 1'b0;
            s_data[u]  = '0;
            t_ready[u] = 1'b1;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_hold_valid();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
